// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-port memory controller for instruction fetch, data read
// and data write over a shared tri-state data bus.
// Optional feature: define MEM_TIMEOUT_EN to abort waits that exceed
// TIMEOUT_CYCLES cycles without inputReady (sets the sticky timeout_err flag).
//
// Handshake: a request (req_fetch/req_read/req_write) is accepted only when the
// block is idle (busy=0, done=0). The accepted request is latched and its
// request lines are ignored until the transaction finishes. Priority is
// write > read > fetch, and requests that lose are dropped. The memory side
// completes a wait on the first rising edge where inputReady=1. done pulses for
// one cycle after completion, and requests are ignored during that cycle.
module mem_port_ctrl #(
  parameter int WORD_SIZE      = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_fetch,
  input  logic                 req_read,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] instruction,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] fetch_count,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // An out-of-range timeout would make the wait counter compare meaningless.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_port_ctrl: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 read_q;
  logic                 write_q;
  logic                 data_oe_q;
  logic                 is_fetch_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] ir_q;
  logic [WORD_SIZE-1:0] mdr_q;
  logic [WORD_SIZE-1:0] fetch_count_q;
  logic [WORD_SIZE-1:0] fetch_count_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q;
  logic       timeout_err_q;
`endif

  // Next fetch count. It wraps naturally at 2^WORD_SIZE.
  always_comb begin
    fetch_count_d = fetch_count_q + 1'b1;
  end

  // Main controller FSM. Every output comes straight from a register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      read_q        <= 1'b0;
      write_q       <= 1'b0;
      data_oe_q     <= 1'b0;
      is_fetch_q    <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      ir_q          <= '0;
      mdr_q         <= '0;
      fetch_count_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (req_write) begin
            state_q   <= S_WR_WAIT;
            busy_q    <= 1'b1;
            write_q   <= 1'b1;
            data_oe_q <= 1'b1;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else if (req_read || req_fetch) begin
            state_q    <= S_RD_WAIT;
            busy_q     <= 1'b1;
            read_q     <= 1'b1;
            addr_q     <= req_addr;
            is_fetch_q <= !req_read;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        S_RD_WAIT: begin
          if (inputReady) begin
            if (is_fetch_q) begin
              ir_q          <= data;
              fetch_count_q <= fetch_count_d;
            end else begin
              mdr_q <= data;
            end
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            read_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_LIMIT) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            read_q        <= 1'b0;
            done_q        <= 1'b1;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        S_WR_WAIT: begin
          if (inputReady) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            write_q   <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b1;
          end
`ifdef MEM_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_LIMIT) begin
            state_q       <= S_DONE;
            busy_q        <= 1'b0;
            write_q       <= 1'b0;
            data_oe_q     <= 1'b0;
            done_q        <= 1'b1;
            timeout_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // The bus is driven only while a write is waiting for acknowledge.
  assign data = data_oe_q ? wdata_q : {WORD_SIZE{1'bz}};

  assign busy        = busy_q;
  assign done        = done_q;
  assign readM       = read_q;
  assign writeM      = write_q;
  assign address     = addr_q;
  assign instruction = ir_q;
  assign mem_data    = mdr_q;
  assign fetch_count = fetch_count_q;
  assign dbg_state_o = state_q;

`ifdef MEM_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: a 16-bit instance plus a 4-bit instance run in
// lockstep on the same stimulus, so that the 4-bit fetch counter wraps.
module tb_mem_port_ctrl;
  localparam int W  = 16;
  localparam int TO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         req_fetch, req_read, req_write, inputReady;
  logic [W-1:0] req_addr, req_wdata;
  logic         tb_drv_en;
  logic [W-1:0] tb_drv;
  wire  [W-1:0] data;
  wire  [3:0]   data4;

  assign data  = tb_drv_en ? tb_drv      : {W{1'bz}};
  assign data4 = tb_drv_en ? tb_drv[3:0] : 4'bzzzz;

  logic         busy, done, readM, writeM, timeout_err;
  logic [W-1:0] instruction, mem_data, address, fetch_count;
  logic [1:0]   dbg_state;

  logic         busy4, done4, readM4, writeM4, timeout_err4;
  logic [3:0]   instruction4, mem_data4, address4, fetch_count4;
  logic [1:0]   dbg_state4;

  mem_port_ctrl #(.WORD_SIZE(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_fetch(req_fetch), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .instruction(instruction), .mem_data(mem_data),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .fetch_count(fetch_count),
    .timeout_err(timeout_err), .dbg_state_o(dbg_state)
  );

  mem_port_ctrl #(.WORD_SIZE(4), .TIMEOUT_CYCLES(TO)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_fetch(req_fetch), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr[3:0]), .req_wdata(req_wdata[3:0]),
    .busy(busy4), .done(done4), .instruction(instruction4), .mem_data(mem_data4),
    .readM(readM4), .writeM(writeM4), .address(address4), .data(data4),
    .inputReady(inputReady), .fetch_count(fetch_count4),
    .timeout_err(timeout_err4), .dbg_state_o(dbg_state4)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];       // read data expected to land in IR or MDR
  logic [W-1:0] exp_ir, exp_mdr, exp_fc;
  logic [W-1:0] hiz;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_ir  = '0;
    exp_mdr = '0;
    exp_fc  = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // One full transaction: request for one cycle, then `delay` wait cycles,
  // then inputReady. Request lines carry junk while busy and in DONE.
  task automatic run_txn(input bit f, input bit r, input bit w,
                         input logic [W-1:0] addr, input logic [W-1:0] wdata,
                         input logic [W-1:0] rdata, input int delay);
    bit           is_wr;
    bit           is_fetch;
    logic [W-1:0] got_val;
    is_wr    = w;
    is_fetch = !w && !r && f;
    @(negedge clk);
    check_eq("idle_busy", W'(busy), W'(0));
    req_fetch = f; req_read = r; req_write = w;
    req_addr  = addr; req_wdata = wdata;
    if (!is_wr) exp_q.push_back(rdata);
    @(negedge clk);
    check_eq("acc_busy",   W'(busy),   W'(1));
    check_eq("acc_addr",   address,    addr);
    check_eq("acc_readM",  W'(readM),  W'(!is_wr));
    check_eq("acc_writeM", W'(writeM), W'(is_wr));
    check_eq("acc_data",   data,       is_wr ? wdata : hiz);
    for (int i = 0; i <= delay; i++) begin
      req_fetch = 1'($urandom_range(0, 1));
      req_read  = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      req_addr  = W'($urandom);
      req_wdata = W'($urandom);
      if (i == delay) begin
        inputReady = 1'b1;
        if (!is_wr) begin tb_drv = rdata; tb_drv_en = 1'b1; end
      end else begin
        inputReady = 1'b0;
        if (!is_wr) begin tb_drv = W'($urandom); tb_drv_en = 1'($urandom_range(0, 1)); end
      end
      @(negedge clk);
      if (i < delay) begin
        check_eq("wait_busy",   W'(busy),   W'(1));
        check_eq("wait_done",   W'(done),   W'(0));
        check_eq("wait_readM",  W'(readM),  W'(!is_wr));
        check_eq("wait_writeM", W'(writeM), W'(is_wr));
        check_eq("wait_addr",   address,    addr);
        if (is_wr) check_eq("wait_data", data, wdata);
      end
    end
    tb_drv_en = 1'b0;
    #1;
    check_eq("done_pulse",  W'(done),   W'(1));
    check_eq("done_busy",   W'(busy),   W'(0));
    check_eq("done_readM",  W'(readM),  W'(0));
    check_eq("done_writeM", W'(writeM), W'(0));
    check_eq("done_data",   data,       hiz);
    if (!is_wr) begin
      got_val = exp_q.pop_front();
      if (is_fetch) begin exp_ir = got_val; exp_fc = exp_fc + 1'b1; end
      else exp_mdr = got_val;
    end
    check_eq("ir",     instruction,       exp_ir);
    check_eq("mdr",    mem_data,          exp_mdr);
    check_eq("fcount", fetch_count,       exp_fc);
    check_eq("tmo",    W'(timeout_err),   W'(0));
    check_eq("ir4",    W'(instruction4),  W'(exp_ir[3:0]));
    check_eq("mdr4",   W'(mem_data4),     W'(exp_mdr[3:0]));
    check_eq("fcnt4",  W'(fetch_count4),  W'(exp_fc[3:0]));
    // DONE must ignore a live request and a still-high inputReady
    req_read = 1'b1;
    @(negedge clk);
    check_eq("post_busy", W'(busy), W'(0));
    check_eq("post_done", W'(done), W'(0));
    check_eq("post_data", data,     hiz);
    req_fetch = 1'b0; req_read = 1'b0; req_write = 1'b0;
    inputReady = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    hiz        = {W{1'bz}};
    reset_n    = 1'b0;
    req_fetch  = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_addr   = '0;   req_wdata = '0;
    inputReady = 1'b0; tb_drv_en = 1'b0; tb_drv = '0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    check_eq("rst_busy",  W'(busy),        W'(0));
    check_eq("rst_done",  W'(done),        W'(0));
    check_eq("rst_rdwr",  W'({readM, writeM}), W'(0));
    check_eq("rst_addr",  address,         W'(0));
    check_eq("rst_ir",    instruction,     W'(0));
    check_eq("rst_mdr",   mem_data,        W'(0));
    check_eq("rst_fc",    fetch_count,     W'(0));
    check_eq("rst_tmo",   W'(timeout_err), W'(0));
    check_eq("rst_data",  data,            hiz);
    reset_n = 1'b1;

    // inputReady while idle must not start anything
    inputReady = 1'b1;
    @(negedge clk);
    check_eq("idle_ready", W'(busy | readM | writeM | done), W'(0));
    inputReady = 1'b0;

    // directed fetch, write, priority
    run_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hA1B2, 3);
    run_txn(1'b0, 1'b0, 1'b1, 16'h0020, 16'h5A5A, 16'h0000, 2);
    run_txn(1'b1, 1'b1, 1'b1, 16'h0030, 16'hBEEF, 16'h0000, 1);
    @(negedge clk);
    check_eq("prio_no_pending", W'(busy | readM | writeM), W'(0));
    run_txn(1'b1, 1'b1, 1'b0, 16'h0034, 16'h0000, 16'h7E57, 0);

    // reset asserted in the middle of a read wait
    @(negedge clk);
    req_read = 1'b1; req_addr = 16'h0040;
    @(negedge clk);
    req_read = 1'b0;
    check_eq("rr_busy", W'(busy), W'(1));
    @(negedge clk);
    inputReady = 1'b1; tb_drv = 16'hFFFF; tb_drv_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rr_readM", W'(readM),   W'(0));
    check_eq("rr_busy0", W'(busy),    W'(0));
    check_eq("rr_ir",    instruction, W'(0));
    check_eq("rr_mdr",   mem_data,    W'(0));
    check_eq("rr_fc",    fetch_count, W'(0));
    check_eq("rr_addr",  address,     W'(0));
    @(negedge clk);
    check_eq("rr_nodone", W'(done),   W'(0));
    check_eq("rr_mdr2",   mem_data,   W'(0));
    inputReady = 1'b0; tb_drv_en = 1'b0;
    reset_n = 1'b1;
    model_reset();

    // wait with no acknowledge
    @(negedge clk);
    req_read = 1'b1; req_addr = 16'h0050;
    @(negedge clk);
    req_read = 1'b0;
    check_eq("nr_busy", W'(busy), W'(1));
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (i < TO) check_eq("nr_wait", W'({busy, done}), W'(2'b10));
    end
    check_eq("to_done",  W'(done),        W'(1));
    check_eq("to_readM", W'(readM),       W'(0));
    check_eq("to_flag",  W'(timeout_err), W'(1));
    @(negedge clk);
    check_eq("to_sticky", W'(timeout_err), W'(1));
    check_eq("to_mdr",    mem_data,        exp_mdr);
`else
    for (int i = 0; i < 40; i++) @(negedge clk);
    check_eq("nr_busy_hold",  W'(busy),        W'(1));
    check_eq("nr_readM_hold", W'(readM),       W'(1));
    check_eq("nr_tmo",        W'(timeout_err), W'(0));
    inputReady = 1'b1; tb_drv = 16'h1234; tb_drv_en = 1'b1;
    @(negedge clk);
    check_eq("nr_done", W'(done),   W'(1));
    check_eq("nr_mdr",  mem_data,   16'h1234);
    exp_mdr = 16'h1234;
    inputReady = 1'b0; tb_drv_en = 1'b0;
`endif
    @(negedge clk);

    // enough fetches to wrap the 4-bit counter
    for (int i = 0; i < 18; i++) begin
      run_txn(1'b1, 1'b0, 1'b0, W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 4));
      if (i == 15) check_eq("wrap4", W'(fetch_count4), W'(0));
    end

    // random mix
    for (int i = 0; i < 30; i++) begin
      run_txn(1'($urandom_range(0, 1)) | 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning the width of the address, data, IR and MDR.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of wait cycles for inputReady before abort; legal range 1..255.
REQ-003 The block SHALL have port clk  in  1  rising-edge clock.
REQ-004 The block SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_fetch  in  1  instruction-fetch request.
REQ-006 The block SHALL have port req_read  in  1  data-read request.
REQ-007 The block SHALL have port req_write  in  1  data-write request.
REQ-008 The block SHALL have port req_addr  in  WORD_SIZE  request address.
REQ-009 The block SHALL have port req_wdata  in  WORD_SIZE  write data.
REQ-010 The block SHALL have port busy  out  1  transaction in progress.
REQ-011 The block SHALL have port done  out  1  one-cycle completion pulse.
REQ-012 The block SHALL have port instruction  out  WORD_SIZE  instruction register (IR).
REQ-013 The block SHALL have port mem_data  out  WORD_SIZE  memory data register (MDR).
REQ-014 The block SHALL have port readM  out  1  memory read strobe.
REQ-015 The block SHALL have port writeM  out  1  memory write strobe.
REQ-016 The block SHALL have port address  out  WORD_SIZE  memory address.
REQ-017 The block SHALL have port data  inout  WORD_SIZE  shared memory bus.
REQ-018 The block SHALL have port inputReady  in  1  memory ready/acknowledge.
REQ-019 The block SHALL have port fetch_count  out  WORD_SIZE  number of completed fetches.
REQ-020 The block SHALL have port timeout_err  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have states IDLE, RD_WAIT, WR_WAIT and DONE; all outputs SHALL be registered.
REQ-022 Requests SHALL be sampled only in IDLE; on simultaneous requests the priority SHALL be write > read > fetch, and non-selected requests SHALL be dropped, not queued.
REQ-023 On acceptance at edge N, address SHALL be set to req_addr, the kind SHALL be latched, and busy=1 from N; for a write, req_wdata SHALL be latched.
REQ-024 In RD_WAIT, readM SHALL be 1 and writeM 0; on the first edge with inputReady=1, data SHALL be captured into IR (fetch) or MDR (read), the other register SHALL be unchanged, and the FSM SHALL go to DONE.
REQ-025 In WR_WAIT, writeM SHALL be 1 and data SHALL be driven with the latched wdata; inputReady=1 SHALL complete the write and the FSM SHALL go to DONE.
REQ-026 data SHALL be high-Z in every state except WR_WAIT.
REQ-027 In DONE, done=1, busy=0, readM=writeM=0 for exactly one cycle, then IDLE; requests SHALL be ignored in DONE; minimum request-to-done spacing is 2 edges.
REQ-028 fetch_count SHALL increment by 1 on each successful fetch completion and wrap modulo 2^WORD_SIZE.
REQ-029 inputReady SHALL be ignored in IDLE and DONE.
REQ-030 Requests changing while busy SHALL have no effect; address and latched wdata SHALL be held until DONE.

Reset
REQ-031 reset_n=0 SHALL force, asynchronously: state IDLE; busy, done, readM, writeM and timeout_err 0; address, IR, MDR, latched wdata and fetch_count 0; data high-Z.
REQ-032 Reset asserted mid-transaction SHALL abort it with no IR/MDR update and no done pulse; operation SHALL resume from IDLE on the first edge after release.

Configuration
REQ-033 With MEM_TIMEOUT_EN defined, a wait counter SHALL clear on entry to RD_WAIT/WR_WAIT and increment each wait cycle; if it reaches TIMEOUT_CYCLES without inputReady, the block SHALL go to DONE with done=1, set timeout_err=1 (sticky until reset), leave IR/MDR/fetch_count unchanged, and drop readM/writeM.
REQ-034 Without MEM_TIMEOUT_EN, the block SHALL wait indefinitely, timeout_err SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-035 Fetch test: req_fetch, addr 0x0010, inputReady after 3 cycles with data 0xA1B2 -> readM=1 for 3+ cycles, instruction=0xA1B2, MDR unchanged, one done pulse, fetch_count=1.
REQ-036 Write test: req_write, addr 0x0020, wdata 0x5A5A -> writeM=1, data=0x5A5A only in WR_WAIT, high-Z before and after, done after inputReady.
REQ-037 Priority test: req_fetch, req_read and req_write all 1 in IDLE -> only the write is performed, followed by IDLE with no pending read or fetch.
REQ-038 Reset test: reset_n low during RD_WAIT with inputReady and data 0xFFFF -> IR/MDR remain 0, no done pulse, readM=0 immediately.
REQ-039 Timeout test (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4): read with inputReady held 0 -> done after 4 wait cycles, timeout_err=1 and held, MDR unchanged; without the macro the same stimulus leaves busy=1 indefinitely.
REQ-040 Wrap test: preload 2^WORD_SIZE-1 fetches (or use WORD_SIZE=4 with 16 fetches) -> fetch_count wraps to 0.
